sr_lru: RTL
===========

SR_LRU -- requirements
Module: sr_lru

Interface
REQ-001 No parameters; fixed 8 entries, 3-bit entry ids.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 lruWrite  input  1  push/touch strobe: mark entry lruAddr as most recently used (MRU).
REQ-005 lruRead  input  1  pop strobe: report least recently used (LRU) entry and make it MRU.
REQ-006 lruAddr  input  3  entry id for push.
REQ-007 lruIn  input  8  reserved; no effect on behaviour.
REQ-008 lruOut  output  8  {5'b0, id of current LRU entry}.
REQ-009 lruMru  output  3  debug: id of current MRU entry.

Function
REQ-010 Block SHALL hold a recency list of 8 slots, slot 0 = LRU, slot 7 = MRU, each slot holding a 3-bit entry id.
REQ-011 The list SHALL always be a permutation of ids 0..7; no id duplicated or lost in any cycle.
REQ-012 lruOut SHALL be combinational from current slot 0, valid in the same cycle as lruRead, with zero latency, so a single-cycle CPU captures it before the edge.
REQ-013 lruMru SHALL be combinational from current slot 7.
REQ-014 Touch(id) at the edge: locate slot k holding id; slots k+1..7 shift down one position; id is written into slot 7; slots 0..k-1 are unchanged.
REQ-015 lruWrite=1, lruRead=0: Touch(lruAddr) at the next rising edge.
REQ-016 lruRead=1, lruWrite=0: Touch(slot 0 id) at the next rising edge; lruOut shows the pre-update value during the strobe cycle.
REQ-017 Both strobes high: write has priority; Touch(lruAddr) only; lruOut still shows pre-update slot 0; no second update.
REQ-018 Neither strobe high: state holds.
REQ-019 Touch of the id already in slot 7: list unchanged.
REQ-020 Touch of the id in slot 0: full rotate; former slot 1 becomes LRU.
REQ-021 Update SHALL complete in one cycle; back-to-back strobes on consecutive cycles SHALL each apply, every one seeing the result of the previous.
REQ-022 lruIn SHALL not affect state or outputs; lruOut[7:3] SHALL always be 0.

Reset
REQ-023 rst_n low SHALL immediately, without waiting for a clock edge, set slot i = i for i = 0..7, so that lruOut = 8'h00 and lruMru = 3'd7.
REQ-024 While rst_n is low, strobes SHALL be ignored.
REQ-025 Reset asserted mid-sequence SHALL discard all history; the first edge after release SHALL behave as from the reset order.
REQ-026 No X SHALL appear on outputs after reset.

Verification
REQ-027 Reset, then 8 consecutive pops -> lruOut reads 0,1,2,3,4,5,6,7; final order is again 0..7; lruMru = 7.
REQ-028 Reset, push 3 -> order 0,1,2,4,5,6,7,3; lruMru = 3; next pop returns 0, then order is 1,2,4,5,6,7,3,0.
REQ-029 Reset, push 7 -> no change; lruOut = 0, lruMru = 7; push 0 -> lruOut = 1, lruMru = 0.
REQ-030 Reset, raise lruWrite and lruRead together with lruAddr = 5 -> lruOut = 0 during that cycle; after the edge order is 0,1,2,3,4,6,7,5.
REQ-031 Random 10k strobes with a queue reference model, lruIn randomised -> outputs match every cycle; permutation invariant holds.
REQ-032 Pushes 2, 4 and pop, then rst_n pulsed low between edges -> outputs return to lruOut = 0, lruMru = 7 immediately, before the next clock edge.

Source files
------------

// File: rtl/sr_lru.sv
// sr_lru: 8-entry true-LRU recency list (slot 0 = LRU, slot 7 = MRU); push/touch or pop strobes.
// Latency: lruOut/lruMru are combinational from current state; every update lands at the next rising edge.
// Backpressure: none; a strobe is accepted every cycle, and write wins when both strobes are high.
module sr_lru (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lruWrite,
  input  logic       lruRead,
  input  logic [2:0] lruAddr,
  input  logic [7:0] lruIn,
  output logic [7:0] lruOut,
  output logic [2:0] lruMru
);

  // Recency list: each slot holds one entry id; contents always form a permutation of 0..7.
  logic [2:0] r_slot [8];

  logic       w_touch;
  logic [2:0] w_id;
  logic [7:0] w_shift;
  logic [2:0] w_next [8];
  logic       w_unused;

  // lruIn is reserved and carries no behaviour.
  assign w_unused = ^lruIn;

  // A write touches lruAddr; a lone pop touches the current LRU id.
  assign w_touch = lruWrite | lruRead;
  assign w_id    = lruWrite ? lruAddr : r_slot[0];

  // Mark every slot at or above the one holding w_id; those slots take their upper neighbour.
  always_comb begin
    logic acc;
    acc = 1'b0;
    w_shift = '0;
    for (int i = 0; i < 8; i++) begin
      acc        = acc | (r_slot[i] == w_id);
      w_shift[i] = acc;
    end
  end

  // Build the post-touch list: shift the marked slots down and put w_id at the MRU end.
  always_comb begin
    for (int i = 0; i < 7; i++) begin
      w_next[i] = w_shift[i] ? r_slot[i+1] : r_slot[i];
    end
    w_next[7] = w_id;
  end

  // Async reset restores identity order; otherwise apply the touch in a single edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        r_slot[i] <= 3'(i);
      end
    end else if (w_touch) begin
      for (int i = 0; i < 8; i++) begin
        r_slot[i] <= w_next[i];
      end
    end
  end

  assign lruOut = {5'b0, r_slot[0]};
  assign lruMru = r_slot[7];

endmodule
